// File: rtl/btn_event_ctrl_pkg.sv
// Shared encodings and width helpers for the front-panel button controller.
package btn_event_ctrl_pkg;

    localparam logic EVT_PRESS  = 1'b0;
    localparam logic EVT_REPEAT = 1'b1;

    localparam int DBC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    function automatic int hold_w(input int delay, input int rate);
        int m;
        m = (delay > rate) ? delay : rate;
        return $clog2(m + 1);
    endfunction

    function automatic int div_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_chan.sv
// One button: 2-flop sync, tick-sampled integrating debounce, press/hold/repeat FSM.
module btn_chan
    import btn_event_ctrl_pkg::*;
#(
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_evt,
    output logic o_evt_kind
);

    localparam int HW = hold_w(REPEAT_DELAY, REPEAT_RATE);
    localparam logic [DBC_W-1:0] STABLE_V = DBC_W'(STABLE_CNT);
    localparam logic [HW-1:0]    DELAY_V  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]    RATE_V   = HW'(REPEAT_RATE);

    logic             r_sync1, r_sync2, r_level;
    logic [DBC_W-1:0] r_cnt;
    logic [HW-1:0]    r_hold;
    btn_state_t       r_state;
    logic             r_evt, r_kind;

    logic             w_flip, w_level_nxt;
    logic [HW-1:0]    w_hold_inc;

    // The FSM looks at the level being written this tick, so a press is
    // reported on the same tick the debouncer accepts it.
    assign w_flip      = (r_sync2 != r_level) && (r_cnt >= STABLE_V - 1'b1);
    assign w_level_nxt = r_level ^ (i_tick & w_flip);
    assign w_hold_inc  = (r_hold == '1) ? r_hold : r_hold + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_evt   <= 1'b0;
            r_kind  <= EVT_PRESS;
        end else begin
            r_evt <= 1'b0;
            if (i_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_level_nxt && !r_level) begin
                            r_evt   <= 1'b1;
                            r_kind  <= EVT_PRESS;
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!w_level_nxt) begin
                            r_state <= ST_IDLE;
                        end else if (w_hold_inc >= DELAY_V) begin
                            r_evt   <= 1'b1;
                            r_kind  <= EVT_REPEAT;
                            r_state <= ST_REPEAT;
                            r_hold  <= '0;
                        end else begin
                            r_hold <= w_hold_inc;
                        end
                    end
                    ST_REPEAT: begin
                        if (!w_level_nxt) begin
                            r_state <= ST_IDLE;
                        end else if (w_hold_inc >= RATE_V) begin
                            r_evt  <= 1'b1;
                            r_kind <= EVT_REPEAT;
                            r_hold <= '0;
                        end else begin
                            r_hold <= w_hold_inc;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_level    = r_level;
    assign o_evt      = r_evt;
    assign o_evt_kind = r_kind;

endmodule

// File: rtl/btn_event_ctrl.sv
// Button front end: shared sample tick, per-button channels, pending bits and
// a fixed-priority arbiter feeding one valid/ready event channel.
module btn_event_ctrl
    import btn_event_ctrl_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_level,
    output logic             o_event_valid,
    output logic [2:0]       o_event_id,
    output logic             o_event_kind,
    input  logic             i_event_ready,
    output logic             o_event_drop
);

    localparam int DIV_W = div_w(TICK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    logic [N_BTN-1:0] w_level, w_evt, w_evt_kind;
    logic [N_BTN-1:0] r_pend, r_kind, w_grab;
    logic             r_valid, r_okind, r_drop;
    logic [2:0]       r_id;
    logic             w_any, w_grab_kind;
    logic [2:0]       w_grab_id;

    assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) r_div <= '0;
        else     r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_chan #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (i_btn_raw[g]),
            .i_tick    (w_tick),
            .o_level   (w_level[g]),
            .o_evt     (w_evt[g]),
            .o_evt_kind(w_evt_kind[g])
        );
    end

    // Lowest pending index wins; a grab only happens while the channel is idle.
    always_comb begin
        w_any       = 1'b0;
        w_grab      = '0;
        w_grab_id   = '0;
        w_grab_kind = EVT_PRESS;
        for (int i = 0; i < N_BTN; i++) begin
            if (r_pend[i] && !w_any) begin
                w_any       = 1'b1;
                w_grab_id   = 3'(i);
                w_grab_kind = r_kind[i];
                w_grab[i]   = !r_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_kind  <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_okind <= EVT_PRESS;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= |(w_evt & r_pend & ~w_grab);
            for (int i = 0; i < N_BTN; i++) begin
                if (w_evt[i]) begin
                    r_pend[i] <= 1'b1;
                    // Coalescing keeps a press rather than letting a repeat hide it.
                    if (r_pend[i] && !w_grab[i])
                        r_kind[i] <= (r_kind[i] == EVT_PRESS || w_evt_kind[i] == EVT_PRESS)
                                     ? EVT_PRESS : EVT_REPEAT;
                    else
                        r_kind[i] <= w_evt_kind[i];
                end else if (w_grab[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (r_valid) begin
                if (i_event_ready) r_valid <= 1'b0;
            end else if (w_any) begin
                r_valid <= 1'b1;
                r_id    <= w_grab_id;
                r_okind <= w_grab_kind;
            end
        end
    end

    assign o_btn_level   = w_level;
    assign o_event_valid = r_valid;
    assign o_event_id    = r_id;
    assign o_event_kind  = r_okind;
    assign o_event_drop  = r_drop;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench: expected events queued at stimulus time, checked on each handshake.
module tb_btn_event_ctrl;

    localparam int N_BTN        = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_CNT   = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    typedef struct packed {
        logic [2:0] id;
        logic       kind;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [N_BTN-1:0] btn_level;
    logic             ev_valid;
    logic [2:0]       ev_id;
    logic             ev_kind;
    logic             ev_ready = 1'b1;
    logic             ev_drop;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_pass   = 0;
    int   drop_cnt = 0;
    int   evt_seen = 0;
    logic prev_acc = 1'b0;

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .N_BTN       (N_BTN),
        .TICK_DIV    (TICK_DIV),
        .STABLE_CNT  (STABLE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_raw    (btn_raw),
        .o_btn_level  (btn_level),
        .o_event_valid(ev_valid),
        .o_event_id   (ev_id),
        .o_event_kind (ev_kind),
        .i_event_ready(ev_ready),
        .o_event_drop (ev_drop)
    );

    // Handshake monitor: pops the scoreboard and checks the idle gap after each accept.
    always @(negedge clk) begin
        exp_t e;
        if (ev_drop === 1'b1) drop_cnt++;
        if (rst) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) begin
                n_total++;
                if (ev_valid !== 1'b0)
                    $display("FAIL valid_gap: event_valid=%b after accept, required 0", ev_valid);
                else n_pass++;
            end
            prev_acc = (ev_valid === 1'b1) && ev_ready;
            if (prev_acc) begin
                evt_seen++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: id=%0d kind=%0d, required no event", ev_id, ev_kind);
                end else begin
                    e = exp_q.pop_front();
                    if ({ev_id, ev_kind} !== {e.id, e.kind})
                        $display("FAIL event_content: id=%0d kind=%0d, required id=%0d kind=%0d",
                                 ev_id, ev_kind, e.id, e.kind);
                    else n_pass++;
                end
            end
        end
    end

    task automatic wait_q(input int k, input int budget);
        int n = 0;
        while (exp_q.size() > k && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (btn_level !== '0) $display("FAIL reset_level: %b, required 0", btn_level); else n_pass++;
        n_total++; if (ev_valid !== 1'b0) $display("FAIL reset_valid: %b, required 0", ev_valid); else n_pass++;
        n_total++; if (ev_id !== 3'd0) $display("FAIL reset_id: %0d, required 0", ev_id); else n_pass++;
        n_total++; if (ev_kind !== 1'b0) $display("FAIL reset_kind: %b, required 0", ev_kind); else n_pass++;
        n_total++; if (ev_drop !== 1'b0) $display("FAIL reset_drop: %b, required 0", ev_drop); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_press();
        int e0, n;
        e0 = evt_seen;
        exp_q.push_back('{id: 3'd1, kind: 1'b0});
        btn_raw[1] = 1'b1;
        n = 0;
        while (btn_level[1] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n < STABLE_CNT*TICK_DIV-1 || n > STABLE_CNT*TICK_DIV+2)
            $display("FAIL press_delay: level rose after %0d cycles, required %0d..%0d",
                     n, STABLE_CNT*TICK_DIV-1, STABLE_CNT*TICK_DIV+2);
        else n_pass++;
        wait_q(0, 20);
        btn_raw[1] = 1'b0;
        n_total++; if (exp_q.size() != 0) $display("FAIL press_event: %0d outstanding, required 0", exp_q.size()); else n_pass++;
        repeat (48) @(negedge clk);
        n_total++; if (btn_level[1] !== 1'b0) $display("FAIL press_release_level: %b, required 0", btn_level[1]); else n_pass++;
        n_total++; if (evt_seen - e0 != 1) $display("FAIL press_count: %0d events, required 1", evt_seen - e0); else n_pass++;
    endtask

    task automatic test_bounce();
        int   e0;
        logic rose;
        e0   = evt_seen;
        rose = 1'b0;
        for (int k = 0; k < 8; k++) begin
            btn_raw[0] = ~btn_raw[0];
            repeat (5) begin
                @(negedge clk);
                if (btn_level[0] === 1'b1) rose = 1'b1;
            end
        end
        btn_raw[0] = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (btn_level[0] === 1'b1) rose = 1'b1;
        end
        n_total++; if (rose) $display("FAIL bounce_level: level rose, required stay 0"); else n_pass++;
        n_total++; if (evt_seen != e0) $display("FAIL bounce_events: %0d events, required 0", evt_seen - e0); else n_pass++;
    endtask

    task automatic test_repeat();
        int e0;
        e0 = evt_seen;
        exp_q.push_back('{id: 3'd2, kind: 1'b0});
        repeat (5) exp_q.push_back('{id: 3'd2, kind: 1'b1});
        btn_raw[2] = 1'b1;
        wait_q(1, 200);
        // Released right after the tick-11 repeat: tick 13 still repeats, tick 15 sees the release.
        btn_raw[2] = 1'b0;
        wait_q(0, 40);
        n_total++; if (exp_q.size() != 0) $display("FAIL repeat_events: %0d outstanding, required 0", exp_q.size()); else n_pass++;
        repeat (48) @(negedge clk);
        n_total++; if (btn_level[2] !== 1'b0) $display("FAIL repeat_release_level: %b, required 0", btn_level[2]); else n_pass++;
        n_total++; if (evt_seen - e0 != 6) $display("FAIL repeat_count: %0d events, required 6", evt_seen - e0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{id: 3'd0, kind: 1'b0});
        exp_q.push_back('{id: 3'd3, kind: 1'b0});
        btn_raw[0] = 1'b1;
        btn_raw[3] = 1'b1;
        wait_q(1, 100);
        btn_raw[0] = 1'b0;
        btn_raw[3] = 1'b0;
        wait_q(0, 20);
        n_total++; if (exp_q.size() != 0) $display("FAIL b2b_events: %0d outstanding, required 0", exp_q.size()); else n_pass++;
        repeat (48) @(negedge clk);
        n_total++; if (btn_level !== '0) $display("FAIL b2b_release_level: %b, required 0", btn_level); else n_pass++;
    endtask

    task automatic test_backpressure();
        int   d0;
        logic seen, stable;
        exp_q.push_back('{id: 3'd1, kind: 1'b0});
        btn_raw[1] = 1'b1;
        wait_q(0, 100);
        ev_ready = 1'b0;
        d0     = drop_cnt;
        seen   = 1'b0;
        stable = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (n == 88) btn_raw[1] = 1'b0;
            if (ev_valid === 1'b1) begin
                seen = 1'b1;
                if (ev_id !== 3'd1 || ev_kind !== 1'b1) stable = 1'b0;
            end else if (seen) begin
                stable = 1'b0;
            end
        end
        n_total++; if (!seen) $display("FAIL bp_presented: no event presented, required repeat id=1"); else n_pass++;
        n_total++; if (!stable) $display("FAIL bp_stable: outputs changed under backpressure, required stable id=1 kind=1"); else n_pass++;
        n_total++; if (drop_cnt - d0 != 9) $display("FAIL bp_drops: %0d drop pulses, required 9", drop_cnt - d0); else n_pass++;
        exp_q.push_back('{id: 3'd1, kind: 1'b1});
        exp_q.push_back('{id: 3'd1, kind: 1'b1});
        ev_ready = 1'b1;
        wait_q(0, 20);
        n_total++; if (exp_q.size() != 0) $display("FAIL bp_delivery: %0d outstanding, required 0", exp_q.size()); else n_pass++;
        repeat (40) @(negedge clk);
        n_total++; if (btn_level[1] !== 1'b0) $display("FAIL bp_release_level: %b, required 0", btn_level[1]); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int n, d0;
        ev_ready   = 1'b0;
        btn_raw[2] = 1'b1;
        n = 0;
        while (!(ev_valid === 1'b1 && btn_level[2] === 1'b1) && n < 80) begin
            @(negedge clk);
            n++;
        end
        n_total++; if (n >= 80) $display("FAIL mrst_setup: no presented press within 80 cycles, required one"); else n_pass++;
        d0  = drop_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (ev_valid !== 1'b0) $display("FAIL mrst_valid: %b, required 0", ev_valid); else n_pass++;
        n_total++; if (btn_level !== '0) $display("FAIL mrst_level: %b, required 0", btn_level); else n_pass++;
        n_total++; if ({ev_id, ev_kind, ev_drop} !== 5'd0) $display("FAIL mrst_outputs: id=%0d kind=%b drop=%b, required 0", ev_id, ev_kind, ev_drop); else n_pass++;
        exp_q.push_back('{id: 3'd2, kind: 1'b0});
        ev_ready = 1'b1;
        n = 0;
        while (btn_level[2] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n < STABLE_CNT*TICK_DIV-1 || n > STABLE_CNT*TICK_DIV+2)
            $display("FAIL mrst_redetect: level rose after %0d cycles, required %0d..%0d",
                     n, STABLE_CNT*TICK_DIV-1, STABLE_CNT*TICK_DIV+2);
        else n_pass++;
        wait_q(0, 20);
        btn_raw[2] = 1'b0;
        n_total++; if (exp_q.size() != 0) $display("FAIL mrst_event: %0d outstanding, required 0", exp_q.size()); else n_pass++;
        n_total++; if (drop_cnt != d0) $display("FAIL mrst_drop: %0d drop pulses, required 0", drop_cnt - d0); else n_pass++;
        repeat (48) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_repeat();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        n_total++; if (exp_q.size() != 0) $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
